// File: rtl/snake_pkg.sv
// Shared snake definitions: cell codes, grid geometry and frame-builder states.
// The game logic block is expected to adopt GRID_W and CELLS from here.
package snake_pkg;

    localparam int GRID_W = 16;
    localparam int CELLS  = GRID_W * GRID_W;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_BODY  = 2'b01,
        CELL_HEAD  = 2'b10,
        CELL_FOOD  = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        FB_IDLE,
        FB_CLEAR,
        FB_FOOD,
        FB_WALK,
        FB_SWAP
    } fb_state_e;

    function automatic cell_t seg_code(input logic [7:0] idx);
        return (idx == 8'd0) ? CELL_HEAD : CELL_BODY;
    endfunction

endpackage

// File: rtl/snake_step_sync.sv
// Synchronizes a slow clock-like signal as data and emits a one-cycle
// pulse on each synchronized rising edge.
module snake_step_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic step_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign step_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/snake_frame_builder.sv
// Builds a double-buffered 16x16 2-bit framebuffer from the snake segment list.
// Optional SNAKE_FRAME_OVER_BLINK_EN blanks alternate frames while game_over.
module snake_frame_builder
    import snake_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             game_clk,
    input  logic [255:0][7:0] positions,
    input  logic [7:0]       length,
    input  logic [7:0]       food_pos,
    input  logic             game_over,
    input  logic [7:0]       pix_addr,
    output logic [1:0]       pix_data,
    output logic             frame_done,
    output logic             busy,
    output logic [7:0]       frame_count
);

    fb_state_e state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] food_q, food_d;
    logic [7:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic       front_q;
    logic [7:0] count_q;
    logic       done_q;
    cell_t      pix_q, pix_d;
    cell_t      fb_q [2][CELLS];

    logic       step;
    logic       clr_back;
    logic       wr_en;
    logic [7:0] wr_addr;
    cell_t      wr_cell;
    logic       swap;
    logic       back_sel;

    snake_step_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .async_i(game_clk),
        .step_o (step)
    );

    assign back_sel = ~front_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        food_d    = food_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        clr_back  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = food_q;
        wr_cell   = CELL_FOOD;
        swap      = 1'b0;

        if (step && state_q != FB_IDLE) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            FB_IDLE: begin
                if (step || pending_q) begin
                    state_d   = FB_CLEAR;
                    len_d     = length;
                    food_d    = food_pos;
                    pending_d = 1'b0;
                end
            end
            FB_CLEAR: begin
                clr_back = 1'b1;
                state_d  = FB_FOOD;
            end
            FB_FOOD: begin
                wr_en   = 1'b1;
                idx_d   = len_q - 8'd1;
                state_d = (len_q == 8'd0) ? FB_SWAP : FB_WALK;
            end
            FB_WALK: begin
                wr_en   = 1'b1;
                wr_addr = positions[idx_q];
                wr_cell = seg_code(idx_q);
                idx_d   = idx_q - 8'd1;
                if (idx_q == 8'd0) begin
                    state_d = FB_SWAP;
                end
            end
            FB_SWAP: begin
                swap = 1'b1;
                // A step seen in this very cycle also queues a rebuild.
                if (pending_q || step) begin
                    state_d   = FB_CLEAR;
                    len_d     = length;
                    food_d    = food_pos;
                    pending_d = 1'b0;
                end else begin
                    state_d = FB_IDLE;
                end
            end
            default: state_d = FB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FB_IDLE;
            len_q     <= '0;
            food_q    <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            front_q   <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            food_q    <= food_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            front_q   <= front_q ^ swap;
            done_q    <= swap;
            if (swap) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < CELLS; i++) begin
                    fb_q[b][i] <= CELL_EMPTY;
                end
            end
        end else if (clr_back) begin
            for (int i = 0; i < CELLS; i++) begin
                fb_q[back_sel][i] <= CELL_EMPTY;
            end
        end else if (wr_en) begin
            fb_q[back_sel][wr_addr] <= wr_cell;
        end
    end

`ifdef SNAKE_FRAME_OVER_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b0;
        end else if (!game_over) begin
            blink_q <= 1'b0;
        end else if (swap) begin
            blink_q <= ~blink_q;
        end
    end

    always_comb begin
        pix_d = fb_q[front_q][pix_addr];
        if (game_over && blink_q) begin
            pix_d = CELL_EMPTY;
        end
    end
`else
    logic unused_game_over;
    assign unused_game_over = game_over;

    always_comb begin
        pix_d = fb_q[front_q][pix_addr];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_q <= CELL_EMPTY;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_data    = pix_q;
    assign frame_done  = done_q;
    assign busy        = (state_q != FB_IDLE);
    assign frame_count = count_q;

endmodule

// File: tb/tb_snake_frame_builder.sv
// Scoreboard bench for snake_frame_builder: frame_done timing and pixel reads.
module tb_snake_frame_builder;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              game_clk = 1'b0;
    logic [255:0][7:0] positions = '0;
    logic [7:0]        length = '0;
    logic [7:0]        food_pos = '0;
    logic              game_over = 1'b0;
    logic [7:0]        pix_addr = '0;
    logic [1:0]        pix_data;
    logic              frame_done;
    logic              busy;
    logic [7:0]        frame_count;

    snake_frame_builder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .game_clk   (game_clk),
        .positions  (positions),
        .length     (length),
        .food_pos   (food_pos),
        .game_over  (game_over),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         c;
        logic [7:0] n;
    } fd_t;

    typedef struct {
        logic [7:0] a;
        logic [1:0] v;
    } rd_t;

    fd_t        fdq[$];
    rd_t        rdq[$];
    int         cyc = 0;
    int         nvec = 0;
    int         nerr = 0;
    logic       rd_issue = 1'b0;
    logic       rd_chk = 1'b0;
    logic [7:0] exp_cnt = '0;
    logic [1:0] exp_fb [256];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rd_chk <= rd_issue;
    end

    task automatic chk(input string nm, input int act, input int want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        fd_t e;
        rd_t r;
        if (frame_done) begin
            if (fdq.size() == 0) begin
                chk("frame_done_unexpected", cyc, -1);
            end else begin
                e = fdq.pop_front();
                chk("frame_done_cycle", cyc, e.c);
                chk("frame_count", int'(frame_count), int'(e.n));
            end
        end
        if (rd_chk) begin
            if (rdq.size() == 0) begin
                chk("read_unexpected", int'(pix_data), -1);
            end else begin
                r = rdq.pop_front();
                chk($sformatf("pix[%0d]", r.a), int'(pix_data), int'(r.v));
            end
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic exp_clear();
        for (int i = 0; i < 256; i++) exp_fb[i] = 2'b00;
    endtask

    task automatic step_go(input int len, output int c);
        @(negedge clk);
        game_clk = 1'b1;
        c = cyc;
        exp_cnt = exp_cnt + 8'd1;
        fdq.push_back('{c + 6 + len, exp_cnt});
    endtask

    task automatic build(input int len);
        int c;
        step_go(len, c);
        wait_to(c + 4);
        game_clk = 1'b0;
        wait_to(c + 8 + len);
    endtask

    task automatic read_frame();
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            pix_addr = a[7:0];
            rd_issue = 1'b1;
            rdq.push_back('{a[7:0], exp_fb[a]});
        end
        @(negedge clk);
        rd_issue = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_clear();
        read_frame();

        // Single head plus food
        length = 8'd1;
        positions[0] = 8'd58;
        food_pos = 8'd144;
        build(1);
        exp_clear();
        exp_fb[58] = 2'b10;
        exp_fb[144] = 2'b11;
        read_frame();

        // Body overwrites food
        length = 8'd3;
        positions[0] = 8'd58;
        positions[1] = 8'd57;
        positions[2] = 8'd56;
        food_pos = 8'd57;
        build(3);
        exp_clear();
        exp_fb[58] = 2'b10;
        exp_fb[57] = 2'b01;
        exp_fb[56] = 2'b01;
        read_frame();

        // Head beats a colliding tail; read cell 58 across the swap
        length = 8'd4;
        positions[0] = 8'd100;
        positions[1] = 8'd101;
        positions[2] = 8'd102;
        positions[3] = 8'd100;
        food_pos = 8'd7;
        step_go(4, c);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            if (cyc == c + 4) game_clk = 1'b0;
            pix_addr = 8'd58;
            rd_issue = 1'b1;
            rdq.push_back('{8'd58, (cyc >= c + 10) ? 2'b00 : 2'b10});
        end
        @(negedge clk);
        rd_issue = 1'b0;
        wait_to(c + 20);
        exp_clear();
        exp_fb[100] = 2'b10;
        exp_fb[101] = 2'b01;
        exp_fb[102] = 2'b01;
        exp_fb[7] = 2'b11;
        read_frame();

        // Empty snake: food only
        length = 8'd0;
        food_pos = 8'd5;
        build(0);
        exp_clear();
        exp_fb[5] = 2'b11;
        read_frame();

        // Queued rebuild; third step dropped
        length = 8'd20;
        for (int i = 0; i < 20; i++) positions[i] = 8'(30 + i);
        food_pos = 8'd0;
        step_go(20, c);
        wait_to(c + 4);
        game_clk = 1'b0;
        wait_to(c + 8);
        game_clk = 1'b1;
        wait_to(c + 12);
        game_clk = 1'b0;
        wait_to(c + 16);
        game_clk = 1'b1;
        wait_to(c + 20);
        game_clk = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        fdq.push_back('{c + 49, exp_cnt});
        wait_to(c + 25);
        chk("busy_in_swap", int'(busy), 1);
        wait_to(c + 26);
        chk("busy_after_swap_pending", int'(busy), 1);
        wait_to(c + 60);
        chk("busy_idle_after_rebuild", int'(busy), 0);
        exp_clear();
        exp_fb[0] = 2'b11;
        exp_fb[30] = 2'b10;
        for (int i = 31; i < 50; i++) exp_fb[i] = 2'b01;
        read_frame();

        // Reset in the middle of WALK
        @(negedge clk);
        pix_addr = 8'd30;
        game_clk = 1'b1;
        c = cyc;
        wait_to(c + 4);
        game_clk = 1'b0;
        wait_to(c + 10);
        chk("pre_reset_pix", int'(pix_data), 2);
        chk("pre_reset_busy", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_pix", int'(pix_data), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(frame_done), 0);
        chk("async_rst_count", int'(frame_count), 0);
        exp_cnt = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_clear();
        read_frame();

        // game_over: blanks alternate frames only with the blink option
        game_over = 1'b1;
        length = 8'd1;
        positions[0] = 8'd58;
        food_pos = 8'd144;
        build(1);
        exp_clear();
`ifndef SNAKE_FRAME_OVER_BLINK_EN
        exp_fb[58] = 2'b10;
        exp_fb[144] = 2'b11;
`endif
        read_frame();
        build(1);
        exp_clear();
        exp_fb[58] = 2'b10;
        exp_fb[144] = 2'b11;
        read_frame();
        game_over = 1'b0;

        repeat (10) @(negedge clk);
        chk("frame_done_outstanding", fdq.size(), 0);
        chk("reads_outstanding", rdq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
